axis_packet_arbiter: RTL and testbench

- Shares one 512-bit AXI-Stream egress among NUM_IN kernel-side streams, with packet granularity.
- Uses round-robin arbitration; a grant is held from the first beat to the beat with tlast.
- Sits in the middleware ahead of the network bridge. Unused inputs are driven by the tie-off block (tvalid=0).
- Output passes through an internal register slice.

---
 rtl/axis_arb_pkg.sv | 36 +++
 rtl/axis_reg_slice.sv | 78 +++++++
 rtl/axis_packet_arbiter.sv | 134 +++++++++++++
 tb/tb_axis_packet_arbiter.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// Shared definitions for the packet-granular AXI-Stream arbiter.
package axis_arb_pkg;

    // Arbiter FSM encodings
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Per-input packet counter width (optional counters)
    localparam int unsigned PKT_CNT_W = 32;

    // Widest request vector the round-robin helper accepts
    localparam int unsigned RR_MAX_IN = 16;

    // First requester after 'last', searching last+1, last+2, ... modulo n.
    // Returns 'last' unchanged when nothing requests.
    function automatic logic [3:0] rr_next(input logic [RR_MAX_IN-1:0] req,
                                           input logic [3:0]           last,
                                           input int unsigned          n);
        logic [3:0] pick;
        int         idx;
        pick = last;
        // Walk from farthest to nearest so the nearest hit is written last
        for (int i = RR_MAX_IN; i >= 1; i--) begin
            if (i <= int'(n)) begin
                idx = (int'(last) + i) % int'(n);
                if (req[idx[3:0]]) begin
                    pick = idx[3:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Two-entry AXI-Stream skid buffer: full throughput, registered outputs.
module axis_reg_slice #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned USER_WIDTH = 64
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_tkeep,
    input  logic                    s_tlast,
    input  logic [USER_WIDTH-1:0]   s_tuser,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic [DATA_WIDTH/8-1:0] m_tkeep,
    output logic                    m_tlast,
    output logic [USER_WIDTH-1:0]   m_tuser
);

    localparam int unsigned PayW = DATA_WIDTH + DATA_WIDTH / 8 + 1 + USER_WIDTH;

    logic            out_valid_q, out_valid_d;
    logic [PayW-1:0] out_q, out_d;
    logic            skid_valid_q, skid_valid_d;
    logic [PayW-1:0] skid_q, skid_d;
    logic [PayW-1:0] in_pay;
    logic            push, pop;

    assign in_pay   = {s_tdata, s_tkeep, s_tlast, s_tuser};
    // Ready only depends on the skid entry, so it is a flop output too
    assign s_tready = ~skid_valid_q;
    assign push     = s_tvalid & ~skid_valid_q;
    assign pop      = out_valid_q & m_tready;

    // Next-state: refill the output stage from skid first, else from input
    always_comb begin
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (!out_valid_q || pop) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = push;
                if (push) begin
                    out_d = in_pay;
                end
            end
        end else if (push) begin
            skid_d       = in_pay;
            skid_valid_d = 1'b1;
        end
    end

    // Storage registers; reset discards both entries
    always_ff @(posedge aclk) begin
        if (areset) begin
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end

    assign m_tvalid = out_valid_q;
    assign {m_tdata, m_tkeep, m_tlast, m_tuser} = out_q;

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream egress among
// NUM_IN inputs, followed by a register slice.
// Optional: define AXIS_ARB_PKT_COUNT_EN to add per-input packet counters.
module axis_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter int unsigned NUM_IN     = 4,
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned USER_WIDTH = 64
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic [NUM_IN-1:0]              s_tvalid,
    output logic [NUM_IN-1:0]              s_tready,
    input  logic [NUM_IN*DATA_WIDTH-1:0]   s_tdata,
    input  logic [NUM_IN*DATA_WIDTH/8-1:0] s_tkeep,
    input  logic [NUM_IN-1:0]              s_tlast,
    input  logic [NUM_IN*USER_WIDTH-1:0]   s_tuser,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic [DATA_WIDTH-1:0]          m_tdata,
    output logic [DATA_WIDTH/8-1:0]        m_tkeep,
    output logic                           m_tlast,
    output logic [USER_WIDTH-1:0]          m_tuser,
    output logic [$clog2(NUM_IN)-1:0]      grant_idx,
    output logic                           busy
`ifdef AXIS_ARB_PKT_COUNT_EN
   ,output logic [NUM_IN*PKT_CNT_W-1:0]    pkt_count
`endif
);

    localparam int unsigned GrantW = $clog2(NUM_IN);
    localparam int unsigned KeepW  = DATA_WIDTH / 8;

    arb_state_e        state_q, state_d;
    logic [GrantW-1:0] grant_q, grant_d;
    logic [GrantW-1:0] last_grant_q, last_grant_d;

    logic                  sl_valid;
    logic                  sl_ready;
    logic [DATA_WIDTH-1:0] sl_tdata;
    logic [KeepW-1:0]      sl_tkeep;
    logic                  sl_tlast;
    logic [USER_WIDTH-1:0] sl_tuser;

    // Granted input's payload feeds the slice
    assign sl_tdata = s_tdata[grant_q * DATA_WIDTH +: DATA_WIDTH];
    assign sl_tkeep = s_tkeep[grant_q * KeepW +: KeepW];
    assign sl_tlast = s_tlast[grant_q];
    assign sl_tuser = s_tuser[grant_q * USER_WIDTH +: USER_WIDTH];

    // Arbitration in IDLE, packet lock in BUSY until tlast is accepted
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        s_tready     = '0;
        sl_valid     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|s_tvalid) begin
                    grant_d = GrantW'(rr_next(RR_MAX_IN'(s_tvalid), 4'(last_grant_q), NUM_IN));
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                s_tready[grant_q] = sl_ready;
                sl_valid          = s_tvalid[grant_q];
                if (s_tvalid[grant_q] && sl_ready && s_tlast[grant_q]) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and grant registers
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= GrantW'(NUM_IN - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign grant_idx = grant_q;
    assign busy      = (state_q == ST_BUSY);

    axis_reg_slice #(
        .DATA_WIDTH (DATA_WIDTH),
        .USER_WIDTH (USER_WIDTH)
    ) u_slice (
        .aclk     (aclk),
        .areset   (areset),
        .s_tvalid (sl_valid),
        .s_tready (sl_ready),
        .s_tdata  (sl_tdata),
        .s_tkeep  (sl_tkeep),
        .s_tlast  (sl_tlast),
        .s_tuser  (sl_tuser),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tlast  (m_tlast),
        .m_tuser  (m_tuser)
    );

`ifdef AXIS_ARB_PKT_COUNT_EN
    logic [NUM_IN*PKT_CNT_W-1:0] cnt_q;

    // Saturating count of accepted tlast beats per input
    always_ff @(posedge aclk) begin
        if (areset) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_IN); i++) begin
                if (s_tvalid[i] && s_tready[i] && s_tlast[i] &&
                    (cnt_q[i*PKT_CNT_W +: PKT_CNT_W] != '1)) begin
                    cnt_q[i*PKT_CNT_W +: PKT_CNT_W] <= cnt_q[i*PKT_CNT_W +: PKT_CNT_W] + 1'b1;
                end
            end
        end
    end

    assign pkt_count = cnt_q;
`endif

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Self-checking bench for axis_packet_arbiter (NUM_IN=4).
// Define AXIS_ARB_PKT_COUNT_EN to also exercise the packet counters.
module tb_axis_packet_arbiter;

    localparam int NI = 4;
    localparam int DW = 512;
    localparam int UW = 64;
    localparam int KW = DW / 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    logic              aclk = 1'b0;
    logic              areset;
    logic [NI-1:0]     s_tvalid;
    logic [NI-1:0]     s_tready;
    logic [NI*DW-1:0]  s_tdata;
    logic [NI*KW-1:0]  s_tkeep;
    logic [NI-1:0]     s_tlast;
    logic [NI*UW-1:0]  s_tuser;
    logic              m_tvalid;
    logic              m_tready;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic              m_tlast;
    logic [UW-1:0]     m_tuser;
    logic [1:0]        grant_idx;
    logic              busy;
`ifdef AXIS_ARB_PKT_COUNT_EN
    logic [NI*32-1:0]  pkt_count;
`endif

    axis_packet_arbiter #(
        .NUM_IN     (NI),
        .DATA_WIDTH (DW),
        .USER_WIDTH (UW)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tdata   (s_tdata),
        .s_tkeep   (s_tkeep),
        .s_tlast   (s_tlast),
        .s_tuser   (s_tuser),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tdata   (m_tdata),
        .m_tkeep   (m_tkeep),
        .m_tlast   (m_tlast),
        .m_tuser   (m_tuser),
        .grant_idx (grant_idx),
        .busy      (busy)
`ifdef AXIS_ARB_PKT_COUNT_EN
       ,.pkt_count (pkt_count)
`endif
    );

    always #5 aclk = ~aclk;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    model_last;
    int    pkts_done [NI];
    beat_t src_q [NI][$];
    beat_t exp_q [$];
    logic  started [NI];

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // Queue one packet of 'len' random beats on input i
    task automatic gen_packet(input int i, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom();
            b.keep = {$urandom(), $urandom()};
            b.user = {8'(i), 24'(k), $urandom()};
            b.last = (k == len - 1);
            src_q[i].push_back(b);
        end
    endtask

    // Reference order: serve whole packets, next non-empty input after the last winner
    task automatic build_expected();
        int ptr [NI];
        int left;
        int idx;
        for (int i = 0; i < NI; i++) ptr[i] = 0;
        forever begin
            left = 0;
            for (int i = 0; i < NI; i++) left += src_q[i].size() - ptr[i];
            if (left == 0) break;
            idx = -1;
            for (int k = 1; k <= NI; k++) begin
                if (idx < 0 && ptr[(model_last + k) % NI] < src_q[(model_last + k) % NI].size())
                    idx = (model_last + k) % NI;
            end
            forever begin
                exp_q.push_back(src_q[idx][ptr[idx]]);
                ptr[idx]++;
                if (src_q[idx][ptr[idx]-1].last) break;
            end
            model_last = idx;
            pkts_done[idx]++;
        end
    endtask

    task automatic apply_drive(input int gap_pct);
        for (int i = 0; i < NI; i++) begin
            if (src_q[i].size() > 0) begin
                s_tvalid[i] = !started[i] || ($urandom_range(99) >= gap_pct);
                s_tdata[i*DW +: DW] = src_q[i][0].data;
                s_tkeep[i*KW +: KW] = src_q[i][0].keep;
                s_tuser[i*UW +: UW] = src_q[i][0].user;
                s_tlast[i]          = src_q[i][0].last;
            end else begin
                s_tvalid[i] = 1'b0;
                s_tlast[i]  = 1'b0;
            end
        end
    endtask

    function automatic logic ready_for(input int mode, input int cyc);
        logic [3:0] pat;
        pat = 4'b1001;
        if (mode == 0) return 1'b1;
        if (mode == 1) return pat[3 - (cyc % 4)];
        return ($urandom_range(99) < 65);
    endfunction

    // Drive queued packets, check egress beats, stalls and slice occupancy
    task automatic run_traffic(input int mode, input int gap_pct, input int budget,
                               output int first_lat);
        logic [NI-1:0] fire_s;
        logic          fire_m;
        logic          prev_stall;
        logic [DW+KW+UW+1:0] prev_out, cur_out;
        beat_t         e, g;
        int            occ;
        first_lat  = -1;
        occ        = 0;
        prev_stall = 1'b0;
        prev_out   = '0;
        for (int i = 0; i < NI; i++) started[i] = 1'b0;
        m_tready = ready_for(mode, 0);
        apply_drive(gap_pct);
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (exp_q.size() == 0) break;
            @(negedge aclk);
            cur_out = {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser};
            if ($countones(s_tready) > 1) begin
                n_fail++;
                $display("FAIL one_ready: s_tready=%b, expected at most one bit", s_tready);
            end
            n_tests++;
            if (m_tvalid !== (occ > 0)) begin
                n_fail++;
                $display("FAIL m_valid_occ: m_tvalid=%b, expected %b (occupancy %0d)",
                         m_tvalid, occ > 0, occ);
            end
            if (occ == 2) begin
                n_tests++;
                if (s_tready !== '0) begin
                    n_fail++;
                    $display("FAIL full_ready: s_tready=%b, expected 0000", s_tready);
                end
            end
            if (prev_stall) begin
                n_tests++;
                if (cur_out !== prev_out) begin
                    n_fail++;
                    $display("FAIL stall_stable: m_* %h, expected %h", cur_out, prev_out);
                end
            end
            fire_s = s_tvalid & s_tready;
            fire_m = m_tvalid & m_tready;
            if (m_tvalid && first_lat < 0) first_lat = cyc;
            if (fire_m) begin
                e = exp_q.pop_front();
                g = {m_tdata, m_tkeep, m_tuser, m_tlast};
                n_tests++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL beat: user=%h last=%b data=%h, expected user=%h last=%b data=%h",
                             g.user, g.last, g.data, e.user, e.last, e.data);
                end
            end
            occ = occ + $countones(fire_s) - int'(fire_m);
            prev_stall = m_tvalid & ~m_tready;
            prev_out   = cur_out;
            @(posedge aclk);
            #1;
            for (int i = 0; i < NI; i++) begin
                if (fire_s[i]) begin
                    e = src_q[i].pop_front();
                    started[i] = !e.last;
                end
            end
            m_tready = ready_for(mode, cyc + 1);
            apply_drive(gap_pct);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL traffic_timeout: %0d beats outstanding, expected 0", exp_q.size());
            exp_q.delete();
            for (int i = 0; i < NI; i++) src_q[i].delete();
        end
        s_tvalid = '0;
        s_tlast  = '0;
    endtask

    task automatic do_reset();
        areset   = 1'b1;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tuser  = '0;
        m_tready = 1'b0;
        repeat (3) @(posedge aclk);
        model_last = NI - 1;
        for (int i = 0; i < NI; i++) pkts_done[i] = 0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge aclk);
        n_tests += 8;
        if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_m_tvalid: %b, expected 0", m_tvalid); end
        if (s_tready !== '0) begin n_fail++; $display("FAIL rst_s_tready: %b, expected 0", s_tready); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: %b, expected 0", busy); end
        if (grant_idx !== 2'd0) begin n_fail++; $display("FAIL rst_grant: %0d, expected 0", grant_idx); end
        if (m_tdata !== '0) begin n_fail++; $display("FAIL rst_m_tdata: %h, expected 0", m_tdata); end
        if (m_tkeep !== '0) begin n_fail++; $display("FAIL rst_m_tkeep: %h, expected 0", m_tkeep); end
        if (m_tlast !== 1'b0) begin n_fail++; $display("FAIL rst_m_tlast: %b, expected 0", m_tlast); end
        if (m_tuser !== '0) begin n_fail++; $display("FAIL rst_m_tuser: %h, expected 0", m_tuser); end
        @(posedge aclk);
        #1;
        areset = 1'b0;
    endtask

    task automatic test_single_packet();
        int lat;
        gen_packet(0, 3);
        build_expected();
        run_traffic(0, 0, 100, lat);
        @(negedge aclk);
        n_tests += 3;
        if (lat !== 2) begin n_fail++; $display("FAIL single_latency: %0d cycles, expected 2", lat); end
        if (grant_idx !== 2'd0) begin n_fail++; $display("FAIL single_grant: %0d, expected 0", grant_idx); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: %b, expected 0", busy); end
        @(posedge aclk);
        #1;
    endtask

    task automatic test_round_robin();
        int lat;
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < NI; i++) gen_packet(i, 2);
        build_expected();
        run_traffic(0, 0, 200, lat);
        @(negedge aclk);
        n_tests++;
        if (int'(grant_idx) !== model_last) begin
            n_fail++;
            $display("FAIL rr_last_grant: %0d, expected %0d", grant_idx, model_last);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic test_backpressure();
        int lat;
        gen_packet(1, 8);
        build_expected();
        run_traffic(1, 0, 200, lat);
    endtask

    task automatic test_random();
        int lat;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NI; i++)
                for (int p = $urandom_range(3); p > 0; p--) gen_packet(i, $urandom_range(6, 1));
            build_expected();
            run_traffic(2, 30, 2000, lat);
        end
    endtask

    // Granted input 2 stalls mid-packet; input 3 must wait for its tlast
    task automatic test_hold_grant();
        bit got;
        m_tready = 1'b1;
        s_tvalid = 4'b0100;
        s_tlast  = 4'b0000;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge aclk);
            got = s_tready[2];
            @(posedge aclk);
            #1;
        end
        n_tests++;
        if (!got) begin n_fail++; $display("FAIL hold_first_grant: no ready on input 2, expected ready"); end
        s_tvalid = 4'b1000;
        s_tlast  = 4'b1000;
        for (int c = 0; c < 5; c++) begin
            @(negedge aclk);
            n_tests += 3;
            if (s_tready[3] !== 1'b0) begin n_fail++; $display("FAIL hold_other_ready: %b, expected 0", s_tready[3]); end
            if (busy !== 1'b1) begin n_fail++; $display("FAIL hold_busy: %b, expected 1", busy); end
            if (grant_idx !== 2'd2) begin n_fail++; $display("FAIL hold_grant: %0d, expected 2", grant_idx); end
            if (c >= 2) begin
                n_tests++;
                if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL hold_drain: m_tvalid=%b, expected 0", m_tvalid); end
            end
            @(posedge aclk);
            #1;
        end
        s_tvalid = 4'b1100;
        s_tlast  = 4'b1100;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge aclk);
            got = s_tready[2];
            @(posedge aclk);
            #1;
        end
        s_tvalid = 4'b1000;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge aclk);
            got = s_tready[3];
            @(posedge aclk);
            #1;
        end
        n_tests++;
        if (!got) begin n_fail++; $display("FAIL hold_release: no ready on input 3, expected ready"); end
        s_tvalid = '0;
        s_tlast  = '0;
        pkts_done[2]++;
        pkts_done[3]++;
        model_last = 3;
        repeat (4) @(posedge aclk);
        #1;
    endtask

    // Reset during beat 2 of a 4-beat packet on input 1
    task automatic test_reset_mid_packet();
        int fires;
        bit got;
        m_tready = 1'b1;
        s_tvalid = 4'b0010;
        s_tlast  = 4'b0000;
        fires = 0;
        for (int c = 0; c < 10 && fires < 1; c++) begin
            @(negedge aclk);
            if (s_tready[1]) fires++;
            @(posedge aclk);
            #1;
        end
        @(negedge aclk);
        areset = 1'b1;
        @(negedge aclk);
        n_tests += 4;
        if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_m_tvalid: %b, expected 0", m_tvalid); end
        if (s_tready !== '0) begin n_fail++; $display("FAIL rmid_s_tready: %b, expected 0", s_tready); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: %b, expected 0", busy); end
        if (grant_idx !== 2'd0) begin n_fail++; $display("FAIL rmid_grant: %0d, expected 0", grant_idx); end
        @(posedge aclk);
        #1;
        areset = 1'b0;
        model_last = NI - 1;
        for (int i = 0; i < NI; i++) pkts_done[i] = 0;
        s_tvalid = 4'b0011;
        s_tlast  = 4'b0011;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge aclk);
            if (s_tready != '0) begin
                got = 1;
                n_tests++;
                if (s_tready !== 4'b0001) begin
                    n_fail++;
                    $display("FAIL rmid_first_grant: s_tready=%b, expected 0001", s_tready);
                end
            end
            @(posedge aclk);
            #1;
        end
        n_tests++;
        if (!got) begin n_fail++; $display("FAIL rmid_no_grant: no ready, expected ready on input 0"); end
        s_tvalid = 4'b0010;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge aclk);
            got = s_tready[1];
            @(posedge aclk);
            #1;
        end
        n_tests++;
        if (!got) begin n_fail++; $display("FAIL rmid_second_grant: no ready on input 1, expected ready"); end
        s_tvalid = '0;
        s_tlast  = '0;
        pkts_done[0]++;
        pkts_done[1]++;
        model_last = 1;
        repeat (4) @(posedge aclk);
        #1;
    endtask

`ifdef AXIS_ARB_PKT_COUNT_EN
    task automatic test_pkt_count();
        int lat;
        for (int p = 0; p < 3; p++) gen_packet(1, 2);
        build_expected();
        run_traffic(0, 0, 200, lat);
        @(negedge aclk);
        for (int i = 0; i < NI; i++) begin
            n_tests++;
            if (pkt_count[i*32 +: 32] !== 32'(pkts_done[i])) begin
                n_fail++;
                $display("FAIL pkt_count[%0d]: %0d, expected %0d", i, pkt_count[i*32 +: 32], pkts_done[i]);
            end
        end
        @(posedge aclk);
        #1;
    endtask
`endif

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_random();
        test_hold_grant();
        test_reset_mid_packet();
`ifdef AXIS_ARB_PKT_COUNT_EN
        test_pkt_count();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
